clk_div_multi: RTL

CLK_DIV_MULTI -- requirements
Module: clk_div_multi

---
 rtl/clk_div_pkg.sv | 7 +
 rtl/clk_div_multi_if.sv | 26 ++
 rtl/clk_div_chan.sv | 62 ++++++
 rtl/clk_div_multi.sv | 58 +++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared defaults and widths for the multi-channel clock divider
package clk_div_pkg;
  localparam int   CNT_W_DEF    = 16;
  localparam int   DEF_HALF_DEF = 50;
  localparam logic IDLE_LVL_DEF = 1'b1;
  localparam int   CH_IDX_W     = 3;
endpackage

// File: rtl/clk_div_multi_if.sv
// rtl/clk_div_multi_if.sv - enable, configuration and divided-clock signal bundle
interface clk_div_multi_if
  import clk_div_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = CNT_W_DEF
);
  logic [NUM_CH-1:0]   ch_en;
  logic                cfg_wr;
  logic [CH_IDX_W-1:0] cfg_ch;
  logic [CNT_W-1:0]    cfg_half;
  logic                cfg_err;
  logic [NUM_CH-1:0]   cfg_pend;
  logic [NUM_CH-1:0]   clk_out;
  logic [NUM_CH-1:0]   tick_rise;

  modport master (
    output ch_en, cfg_wr, cfg_ch, cfg_half,
    input  cfg_err, cfg_pend, clk_out, tick_rise
  );

  modport slave (
    input  ch_en, cfg_wr, cfg_ch, cfg_half,
    output cfg_err, cfg_pend, clk_out, tick_rise
  );
endinterface

// File: rtl/clk_div_chan.sv
// rtl/clk_div_chan.sv - one divider channel: half-period counter, pending/active half, toggle
module clk_div_chan #(
  parameter int   CNT_W    = 16,
  parameter int   DEF_HALF = 50,
  parameter logic IDLE_LVL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_half,
  output logic             clk_out,
  output logic             tick_rise,
  output logic             pend
);
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] active_half;
  logic [CNT_W-1:0] pending;
  logic             boundary;
  logic             apply;

  // active_half is never zero, so the subtraction cannot wrap
  assign boundary = (cnt == active_half - CNT_W'(1));
  // a pending value lands only where it cannot cut a half-period short
  assign apply    = pend & (~en | boundary);

  // counter, output toggle, rising tick and pending-to-active hand-over
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      active_half <= CNT_W'(DEF_HALF);
      pending     <= '0;
      pend        <= 1'b0;
      clk_out     <= IDLE_LVL;
      tick_rise   <= 1'b0;
    end else begin
      tick_rise <= 1'b0;
      if (en) begin
        if (boundary) begin
          cnt       <= '0;
          clk_out   <= ~clk_out;
          tick_rise <= ~clk_out;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt     <= '0;
        clk_out <= IDLE_LVL;
      end
      // the old pending value is consumed even when a new write lands in the same cycle
      if (apply) begin
        active_half <= pending;
      end
      if (wr) begin
        pending <= wr_half;
        pend    <= 1'b1;
      end else if (apply) begin
        pend <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/clk_div_multi.sv
// rtl/clk_div_multi.sv - multi-channel clock divider top: write decode, error pulse, channel array
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int   NUM_CH   = 2,
  parameter int   CNT_W    = CNT_W_DEF,
  parameter int   DEF_HALF = DEF_HALF_DEF,
  parameter logic IDLE_LVL = IDLE_LVL_DEF
) (
  input  logic            clk,
  input  logic            rst,
  clk_div_multi_if.slave  bus
);
  localparam int IDX_W1 = CH_IDX_W + 1;

  logic              ch_ok;
  logic              half_ok;
  logic              wr_ok;
  logic              err_q;
  logic [NUM_CH-1:0] out_v;
  logic [NUM_CH-1:0] tick_v;
  logic [NUM_CH-1:0] pend_v;

  assign ch_ok   = ({1'b0, bus.cfg_ch} < IDX_W1'(NUM_CH));
  assign half_ok = (bus.cfg_half != '0);
  assign wr_ok   = bus.cfg_wr & ch_ok & half_ok;

  // rejected writes change nothing and only raise a one-cycle error pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= bus.cfg_wr & ~(ch_ok & half_ok);
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_div_chan #(
      .CNT_W    (CNT_W),
      .DEF_HALF (DEF_HALF),
      .IDLE_LVL (IDLE_LVL)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .en        (bus.ch_en[i]),
      .wr        (wr_ok & (bus.cfg_ch == CH_IDX_W'(i))),
      .wr_half   (bus.cfg_half),
      .clk_out   (out_v[i]),
      .tick_rise (tick_v[i]),
      .pend      (pend_v[i])
    );
  end

  assign bus.cfg_err   = err_q;
  assign bus.clk_out   = out_v;
  assign bus.tick_rise = tick_v;
  assign bus.cfg_pend  = pend_v;
endmodule
